// File: rtl/ifetch_unit.sv
// Instruction fetch stage for the single-cycle data path.
//
// Owns the architectural PC, issues one word fetch at a time to instruction
// memory, and holds the returned instruction and its PC until the data path
// commits it. A flush redirects fetch to flush_pc in any state and wins over a
// commit in the same cycle.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   pc_src           commit selects br_target (1) or pc + 4 (0)
//   br_target        branch/jump target from the ALU
//   advance          data path commits the held instruction this cycle
//   flush, flush_pc  redirect fetch, discarding any in-flight work
//   imem_req_*       fetch request (valid/ready), word address
//   imem_rsp_*       fetch response (valid only, in order, one outstanding)
//   instr_valid      instr/pc_now hold a valid instruction
//   instr            held instruction, NOP_INSTR when nothing is held
//   pc_now           PC register (address of the held instruction)
//   pc_plus4         pc_now + 4, wrapping
//   misaligned       one-cycle pulse after a target with bits [1:0] != 0
//   instret          committed instruction count, wrapping
module ifetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_src,
  input  logic [31:0] br_target,
  input  logic        advance,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc_now,
  output logic [31:0] pc_plus4,
  output logic        misaligned,
  output logic [31:0] instret
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StHold
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] instret_q;
  logic        instr_valid_q;
  logic        misaligned_q;
  // Set while the outstanding response belongs to a request made before a flush.
  logic        drop_q;

  logic [31:0] flush_pc_al;
  logic [31:0] br_target_al;
  logic [31:0] pc_inc;
  logic [31:0] commit_pc;
  logic        commit_mis;

  // Targets are word-aligned on load; the dropped low bits only raise misaligned.
  assign flush_pc_al  = {flush_pc[31:2], 2'b00};
  assign br_target_al = {br_target[31:2], 2'b00};
  assign pc_inc       = pc_q + 32'd4;
  assign commit_pc    = pc_src ? br_target_al : pc_inc;
  assign commit_mis   = pc_src & (|br_target[1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instret_q     <= 32'd0;
      instr_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      misaligned_q <= 1'b0;
      if (flush) begin
        pc_q          <= flush_pc_al;
        misaligned_q  <= |flush_pc[1:0];
        instr_valid_q <= 1'b0;
        instr_q       <= NOP_INSTR;
        unique case (state_q)
          StIdle: state_q <= StReq;
          StReq: begin
            // Already accepted: the response for the old PC must be thrown away.
            if (imem_req_ready) begin
              drop_q  <= 1'b1;
              state_q <= StWait;
            end
          end
          StWait: begin
            // A response arriving with the flush is the stale one; refetch at once.
            if (imem_rsp_valid) begin
              drop_q  <= 1'b0;
              state_q <= StReq;
            end else begin
              drop_q <= 1'b1;
            end
          end
          StHold:  state_q <= StReq;
          default: state_q <= StIdle;
        endcase
      end else begin
        unique case (state_q)
          StIdle: state_q <= StReq;
          StReq: begin
            if (imem_req_ready) begin
              state_q <= StWait;
            end
          end
          StWait: begin
            if (imem_rsp_valid) begin
              if (drop_q) begin
                drop_q  <= 1'b0;
                state_q <= StReq;
              end else begin
                instr_q       <= imem_rsp_data;
                instr_valid_q <= 1'b1;
                state_q       <= StHold;
              end
            end
          end
          StHold: begin
            if (advance) begin
              pc_q          <= commit_pc;
              misaligned_q  <= commit_mis;
              instr_valid_q <= 1'b0;
              instr_q       <= NOP_INSTR;
              instret_q     <= instret_q + 32'd1;
              state_q       <= StReq;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // Decoded straight from the state flop, so no input-to-output path.
  assign imem_req_valid = (state_q == StReq);
  assign imem_req_addr  = pc_q;
  assign instr_valid    = instr_valid_q;
  assign instr          = instr_q;
  assign pc_now         = pc_q;
  assign pc_plus4       = pc_inc;
  assign misaligned     = misaligned_q;
  assign instret        = instret_q;

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        pc_src;
  logic [31:0] br_target;
  logic        advance;
  logic        flush;
  logic [31:0] flush_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc_now;
  logic [31:0] pc_plus4;
  logic        misaligned;
  logic [31:0] instret;

  ifetch_unit #(
    .RESET_PC (RST_PC),
    .NOP_INSTR(NOP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_src        (pc_src),
    .br_target     (br_target),
    .advance       (advance),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .pc_now        (pc_now),
    .pc_plus4      (pc_plus4),
    .misaligned    (misaligned),
    .instret       (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory model: one outstanding fetch, response lat cycles after acceptance.
  logic        mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          lat_cfg;
  bit          rand_lat;
  bit          ready_knob;
  bit          force_en;
  logic [31:0] force_data;
  logic [31:0] acc_q[$];

  // Reference model of the architectural state.
  logic [31:0] exp_pc;
  logic [31:0] exp_instret;
  logic        exp_mis;
  int          commits;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1;
  endfunction

  task automatic drive_mem();
    imem_rsp_valid = mem_busy && (mem_cnt == 0);
    imem_rsp_data  = force_en ? force_data : mem_word(mem_addr);
    imem_req_ready = ready_knob && !mem_busy;
  endtask

  task automatic model_reset();
    exp_pc      = RST_PC;
    exp_instret = 32'd0;
    exp_mis     = 1'b0;
  endtask

  // One clock: sample the cycle at negedge, advance models, check after the edge.
  task automatic tick();
    logic        s_rv, s_rdy, s_rsp, s_iv, s_fl, s_adv, s_src;
    logic [31:0] s_addr, s_br, s_fpc;
    bit          hold_req, hold_iv, clr_iv;
    @(negedge clk);
    s_rv   = imem_req_valid;
    s_rdy  = imem_req_ready;
    s_rsp  = imem_rsp_valid;
    s_iv   = instr_valid;
    s_fl   = flush;
    s_adv  = advance;
    s_src  = pc_src;
    s_addr = imem_req_addr;
    s_br   = br_target;
    s_fpc  = flush_pc;
    if (s_rsp) mem_busy = 1'b0;
    else if (mem_busy && mem_cnt > 0) mem_cnt--;
    if (s_rv && s_rdy) begin
      mem_busy = 1'b1;
      mem_addr = s_addr;
      mem_cnt  = (rand_lat ? int'($urandom_range(1, 3)) : lat_cfg) - 1;
      acc_q.push_back(s_addr);
    end
    exp_mis = 1'b0;
    if (s_fl) begin
      exp_pc  = s_fpc & ~32'h3;
      exp_mis = |s_fpc[1:0];
    end else if (s_adv && s_iv) begin
      exp_pc  = s_src ? (s_br & ~32'h3) : exp_pc + 32'd4;
      exp_mis = s_src && (|s_br[1:0]);
      exp_instret++;
      commits++;
    end
    hold_req = s_rv && !s_rdy && !s_fl;
    hold_iv  = s_iv && !s_adv && !s_fl;
    clr_iv   = s_fl || (s_iv && s_adv);
    @(posedge clk);
    #1;
    drive_mem();
    check("pc_now", pc_now, exp_pc);
    check("req_addr", imem_req_addr, exp_pc);
    check("pc_plus4", pc_plus4, exp_pc + 32'd4);
    check("instret", instret, exp_instret);
    check("misaligned", misaligned, exp_mis);
    check("instr", instr, instr_valid ? mem_word(exp_pc) : NOP);
    check("req_while_valid", instr_valid && imem_req_valid, 0);
    if (hold_req) check("req_hold", imem_req_valid, 1);
    if (hold_iv) check("valid_hold", instr_valid, 1);
    if (clr_iv) check("valid_clear", instr_valid, 0);
  endtask

  task automatic wait_iv(output int n);
    n = 0;
    while (!instr_valid && n < 50) begin
      tick();
      n++;
    end
    check("instr_valid_reached", instr_valid, 1);
  endtask

  task automatic commit(input bit src, input logic [31:0] br, input bit fl,
                        input logic [31:0] fpc);
    advance   = 1'b1;
    pc_src    = src;
    br_target = br;
    flush     = fl;
    flush_pc  = fpc;
    tick();
    advance   = 1'b0;
    pc_src    = 1'b0;
    flush     = 1'b0;
  endtask

  typedef struct {
    bit          src;
    logic [31:0] br;
    bit          fl;
    logic [31:0] fpc;
    logic [31:0] exp_pc;
    bit          exp_mis;
    int          inc;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n;
    int sz;
    int ret_cnt;
    int c0;
    n_vec = 0;
    n_bad = 0;
    commits = 0;
    vecs[0] = '{1'b1, 32'h0000_0102, 1'b0, 32'h0, 32'h0000_0100, 1'b1, 1};
    vecs[1] = '{1'b0, 32'h0000_0000, 1'b0, 32'h0, 32'h0000_0104, 1'b0, 1};
    vecs[2] = '{1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0, 32'hFFFF_FFFC, 1'b1, 1};
    vecs[3] = '{1'b0, 32'h0000_0000, 1'b0, 32'h0, 32'h0000_0000, 1'b0, 1};
    vecs[4] = '{1'b0, 32'h0000_0000, 1'b1, 32'h0000_0401, 32'h0000_0400, 1'b1, 0};
    vecs[5] = '{1'b1, 32'h0000_0010, 1'b1, 32'h0000_0300, 32'h0000_0300, 1'b0, 0};
    vecs[6] = '{1'b1, 32'h0000_0047, 1'b0, 32'h0, 32'h0000_0044, 1'b1, 1};
    vecs[7] = '{1'b1, 32'h0000_0080, 1'b0, 32'h0, 32'h0000_0080, 1'b0, 1};

    rst        = 1'b1;
    pc_src     = 1'b0;
    br_target  = 32'h0;
    advance    = 1'b0;
    flush      = 1'b0;
    flush_pc   = 32'h0;
    mem_busy   = 1'b0;
    mem_cnt    = 0;
    mem_addr   = 32'h0;
    lat_cfg    = 1;
    rand_lat   = 1'b0;
    ready_knob = 1'b1;
    force_en   = 1'b0;
    force_data = 32'h0;
    drive_mem();
    model_reset();

    // Reset values, then first-fetch latency and three back-to-back commits.
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_instr", instr, NOP);
    check("rst_pc", pc_now, RST_PC);
    check("rst_instret", instret, 0);
    rst = 1'b0;
    n = 0;
    while (!instr_valid && n < 20) begin
      tick();
      n++;
    end
    check("first_valid_latency", n, 3);
    check("first_instr", instr, mem_word(32'h0));
    for (int i = 0; i < 3; i++) begin
      commit(1'b0, 32'h0, 1'b0, 32'h0);
      wait_iv(n);
    end
    check("req0_addr", acc_q[0], 32'h0);
    check("req1_addr", acc_q[1], 32'h4);
    check("req2_addr", acc_q[2], 32'h8);
    check("instret_3", instret, 3);

    // Table of commit / flush redirects with alignment and wrap cases.
    ret_cnt = 3;
    for (int i = 0; i < 8; i++) begin
      wait_iv(n);
      commit(vecs[i].src, vecs[i].br, vecs[i].fl, vecs[i].fpc);
      ret_cnt += vecs[i].inc;
      check($sformatf("vec%0d_pc", i), pc_now, vecs[i].exp_pc);
      check($sformatf("vec%0d_mis", i), misaligned, vecs[i].exp_mis);
      check($sformatf("vec%0d_instret", i), instret, ret_cnt);
      check($sformatf("vec%0d_valid", i), instr_valid, 0);
      tick();
      check($sformatf("vec%0d_mis_pulse", i), misaligned, 0);
      wait_iv(n);
      check($sformatf("vec%0d_instr", i), instr, mem_word(vecs[i].exp_pc));
      check($sformatf("vec%0d_fetch", i), acc_q[$], vecs[i].exp_pc);
    end

    // Request stalled by ready low for five cycles.
    ready_knob = 1'b0;
    commit(1'b0, 32'h0, 1'b0, 32'h0);
    sz = acc_q.size();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", imem_req_valid, 1);
      check("stall_addr", imem_req_addr, 32'h84);
      tick();
    end
    check("stall_no_accept", acc_q.size(), sz);
    ready_knob = 1'b1;
    wait_iv(n);
    check("stall_instr", instr, mem_word(32'h84));

    // Flush while waiting; the stale response must be discarded.
    lat_cfg = 3;
    commit(1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    check("wait_accept", acc_q[$], 32'h88);
    force_en   = 1'b1;
    force_data = 32'hDEAD_BEEF;
    flush      = 1'b1;
    flush_pc   = 32'h200;
    tick();
    flush = 1'b0;
    n = 0;
    while (mem_busy && n < 10) begin
      check("stale_valid", instr_valid, 0);
      tick();
      n++;
    end
    force_en = 1'b0;
    lat_cfg  = 1;
    wait_iv(n);
    check("flush_pc_now", pc_now, 32'h200);
    check("flush_instr", instr, mem_word(32'h200));
    check("flush_fetch", acc_q[$], 32'h200);

    // Asynchronous reset in the middle of a wait; the late response is ignored.
    lat_cfg = 4;
    commit(1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_req_valid", imem_req_valid, 0);
    check("mid_rst_instr_valid", instr_valid, 0);
    check("mid_rst_instr", instr, NOP);
    check("mid_rst_pc", pc_now, RST_PC);
    check("mid_rst_instret", instret, 0);
    check("mid_rst_mis", misaligned, 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    lat_cfg = 1;
    wait_iv(n);
    check("restart_pc", pc_now, RST_PC);
    check("restart_instr", instr, mem_word(RST_PC));
    check("restart_fetch", acc_q[$], RST_PC);

    // Randomized traffic against the reference model.
    rand_lat = 1'b1;
    c0 = commits;
    for (int i = 0; i < 3000; i++) begin
      ready_knob = ($urandom_range(0, 3) != 0);
      advance    = $urandom_range(0, 1) != 0;
      pc_src     = $urandom_range(0, 1) != 0;
      br_target  = $urandom;
      flush      = ($urandom_range(0, 15) == 0);
      flush_pc   = $urandom;
      tick();
    end
    advance = 1'b0;
    flush   = 1'b0;
    check("random_progress", (commits - c0) >= 100, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
